// File: rtl/pwm_motor_driver.sv
// Motor-side operator interface: switch synchronisers, STANDBY/RUN/HOLD control,
// duty level 0-9, period-aligned PWM output and an active-low gfedcba level readout.
module pwm_motor_driver #(
    parameter int unsigned PERIOD_CYCLES = 100,
    parameter int unsigned START_LEVEL   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       swt_start_stop,
    input  logic       swt_increase,
    input  logic       swt_decrease,
    output logic       motor_pwm,
    output logic       motor_running,
    output logic [3:0] level,
    output logic [6:0] display
);

    localparam int unsigned CW   = $clog2(PERIOD_CYCLES);
    localparam int unsigned STEP = PERIOD_CYCLES / 10;

    localparam logic [CW-1:0] CNT_LAST  = CW'(PERIOD_CYCLES - 1);
    localparam logic [CW-1:0] STEP_C    = CW'(STEP);
    localparam logic [3:0]    START_LVL = 4'(START_LEVEL);
    localparam logic [3:0]    MAX_LVL   = 4'd9;

    typedef enum logic [1:0] {
        STANDBY,
        RUN,
        HOLD
    } state_t;

    state_t state, state_next;

    // start_stop is consumed as a level, so it only needs the two metastability flops
    logic ss_s1, ss_s2;
    logic inc_s1, inc_s2, inc_s3;
    logic dec_s1, dec_s2, dec_s3;
    logic inc_pulse, dec_pulse, both_held;

    logic [3:0]    level_q, level_next;
    logic [3:0]    duty_q, duty_eff;
    logic [CW-1:0] cnt, cnt_next;
    logic [CW-1:0] duty_ext, threshold;
    logic          pwm_next;
    logic [6:0]    seg_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_s1  <= 1'b0;
            ss_s2  <= 1'b0;
            inc_s1 <= 1'b0;
            inc_s2 <= 1'b0;
            inc_s3 <= 1'b0;
            dec_s1 <= 1'b0;
            dec_s2 <= 1'b0;
            dec_s3 <= 1'b0;
        end else begin
            ss_s1  <= swt_start_stop;
            ss_s2  <= ss_s1;
            inc_s1 <= swt_increase;
            inc_s2 <= inc_s1;
            inc_s3 <= inc_s2;
            dec_s1 <= swt_decrease;
            dec_s2 <= dec_s1;
            dec_s3 <= dec_s2;
        end
    end

    assign inc_pulse = inc_s2 & ~inc_s3;
    assign dec_pulse = dec_s2 & ~dec_s3;
    assign both_held = inc_s2 & dec_s2;

    always_comb begin
        state_next = state;
        unique case (state)
            STANDBY: begin
                if (ss_s2) state_next = RUN;
            end
            RUN: begin
                if (!ss_s2)         state_next = STANDBY;
                else if (both_held) state_next = HOLD;
            end
            HOLD: begin
                if (!ss_s2)          state_next = STANDBY;
                else if (!both_held) state_next = RUN;
            end
            default: state_next = STANDBY;
        endcase
    end

    // Level decisions look at the next state so a stop wins over a coincident
    // press, and a press that coincides with entering HOLD is ignored.
    always_comb begin
        level_next = level_q;
        if (state_next == STANDBY) begin
            level_next = '0;
        end else if (state == STANDBY) begin
            level_next = START_LVL;
        end else if (state == RUN && state_next == RUN) begin
            if (inc_pulse && !dec_pulse && level_q != MAX_LVL) begin
                level_next = level_q + 4'd1;
            end else if (dec_pulse && !inc_pulse && level_q != 4'd0) begin
                level_next = level_q - 4'd1;
            end
        end
    end

    always_comb begin
        cnt_next = cnt + CW'(1);
        if (state == STANDBY || state_next == STANDBY) begin
            cnt_next = '0;
        end else if (cnt == CNT_LAST) begin
            cnt_next = '0;
        end
    end

    // The shadow is transparent at cnt == 0 so the new duty governs the very
    // first cycle of the period it was loaded for.
    assign duty_eff  = (cnt == '0) ? level_q : duty_q;
    assign duty_ext  = CW'(duty_eff);
    assign threshold = duty_ext * STEP_C;
    assign pwm_next  = (state_next == RUN) && (cnt < threshold);

    always_comb begin
        seg_next = 7'b1111111;
        unique case (level_q)
            4'd0:    seg_next = 7'b1000000;
            4'd1:    seg_next = 7'b1111001;
            4'd2:    seg_next = 7'b0100100;
            4'd3:    seg_next = 7'b0110000;
            4'd4:    seg_next = 7'b0011001;
            4'd5:    seg_next = 7'b0010010;
            4'd6:    seg_next = 7'b0000010;
            4'd7:    seg_next = 7'b1111000;
            4'd8:    seg_next = 7'b0000000;
            4'd9:    seg_next = 7'b0010000;
            default: seg_next = 7'b1111111;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= STANDBY;
            level_q       <= '0;
            cnt           <= '0;
            duty_q        <= '0;
            motor_pwm     <= 1'b0;
            motor_running <= 1'b0;
            display       <= 7'b1000000;
        end else begin
            state         <= state_next;
            level_q       <= level_next;
            cnt           <= cnt_next;
            duty_q        <= duty_eff;
            motor_pwm     <= pwm_next;
            motor_running <= (state != STANDBY);
            display       <= seg_next;
        end
    end

    assign level = level_q;

endmodule

// File: doc/pwm_motor_driver.md
# pwm_motor_driver

Motor-side end of the operator-switch interface. Synchronises the start/stop, increase and decrease switches, holds a duty level 0–9, and generates a glitch-free PWM waveform with a run indicator and a 7-segment level readout. It sits between the board switches and the motor power stage. It replaces the level-only motor_pwm of the operator FSM with a true duty-cycle output.

## Interface
- PERIOD_CYCLES, 100, PWM period in clk cycles; must be a multiple of 10 and at least 10.
- START_LEVEL, 5, duty level loaded when the motor starts (0–9).
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- swt_start_stop  input  1  asynchronous level; 1 = run request.
- swt_increase  input  1  asynchronous; a rising edge raises the level by 1.
- swt_decrease  input  1  asynchronous; a rising edge lowers the level by 1.
- motor_pwm  output  1  registered PWM output.
- motor_running  output  1  registered; 1 in RUN or HOLD.
- level  output  4  registered current duty level, 0–9.
- display  output  7  registered 7-segment code, active-low, bit order gfedcba.

## Operation
- **Input synchronisers:** each switch passes through a 2-FF synchroniser and then a third delay flop. For increase and decrease, a pulse is `s2 & ~s3`. start_stop is used as a level (`s2`).
- **FSM states:** STANDBY (reset state), RUN, HOLD.
  - STANDBY -> RUN when synced start_stop = 1. On entry, level is loaded with START_LEVEL.
  - RUN -> HOLD when synced increase and synced decrease are both 1.
  - HOLD -> RUN when they are not both 1.
  - RUN or HOLD -> STANDBY whenever synced start_stop = 0. This has priority over every other transition.
- **Level register:**
  - STANDBY: forced to 0.
  - RUN: an inc pulse increments and saturates at 9. A dec pulse decrements and saturates at 0. If inc and dec pulses arrive in the same cycle, level does not change.
  - HOLD: level is frozen and pulses are ignored.
- **PWM counter:** `cnt` counts 0..PERIOD_CYCLES-1 and wraps. It is held at 0 in STANDBY and starts counting on the first RUN cycle.
  - Duty shadow `duty_q` (4 bits) loads `level` when `cnt == 0`. Level changes therefore only take effect at a period boundary.
  - Threshold is `duty_q * (PERIOD_CYCLES/10)`, computed at counter width, with no overflow for the allowed parameters.
  - `motor_pwm` is 1 in RUN when `cnt < threshold`, and 0 otherwise.
  - Level 0 gives a constant 0; level 9 gives 90 % high.
  - HOLD forces `motor_pwm` to 0 while `cnt` keeps running.
- **motor_running** = 1 in RUN or HOLD.
- **Display** is decoded from `level`, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - any other value = 1111111

## Timing
- **Reset values:**
  - state = STANDBY
  - all synchroniser flops, cnt and duty_q = 0
  - motor_pwm = 0, motor_running = 0, level = 0, display = 1000000
- **Input latency:**
  - An input rising before edge N is seen in `s2` after edge N+1.
  - The state or level change is visible after edge N+2.
  - motor_running and display follow one edge later, after N+3.
- **PWM start:** the first `cnt == 0` in RUN loads duty_q = START_LEVEL. motor_pwm rises one edge after the state enters RUN.
- **Duty change latency:** a level change appears on motor_pwm at the first period start after the change. The worst case is PERIOD_CYCLES + 1 cycles.
- **Pulse rate:** one switch press produces exactly one pulse. Holding a switch does not auto-repeat.
- **Reset mid-operation:** all outputs return to their reset values immediately and asynchronously. Operation resumes from STANDBY on the first edge after rst deasserts.
- **Stop mid-period:** motor_pwm drops to 0 on the same edge that state becomes STANDBY. The counter is not allowed to finish its period.

## Test plan
- **Reset and idle:** assert rst mid-RUN at level 7 -> all outputs go to reset values without waiting for a clock edge. With start_stop = 0, outputs stay at 0 and display stays 1000000.
- **Start:** start_stop 0->1 -> motor_running = 1 and level = 5 within 4 cycles. motor_pwm is high for 50 and low for 50 of each 100-cycle period. display = 0010010.
- **Saturation:** 6 increase presses (each high for 5 cycles, low for 5) -> level = 9 with 90/10 duty, display 0010000. Then 12 decrease presses -> level = 0 and motor_pwm held at 0.
- **Period-boundary update:** an increase press at cnt = 20 while at level 3 -> duty stays 30 high for the rest of that period. The next period is 40 high. No runt or extra pulse appears.
- **Hold:** both increase and decrease high in RUN -> motor_pwm = 0 and motor_running = 1, with level unchanged. Release only decrease -> RUN resumes at the same level. An increase edge seen while in HOLD does not change the level.
- **Stop priority:** start_stop goes to 0 in the same cycle as an increase press at level 4 -> state STANDBY, level 0, motor_pwm 0 and motor_running 0 within 3 edges. No level 5 appears on display.
